degree_table: RTL and testbench

Parametrised in-degree counter table for the graph-processing pipeline; successor to the single-width in-degree list. It accumulates per-node in-degree while edges stream in, then serves decrements from the topological-sort scheduler, returning each post-decrement degree with a zero flag. Adds over the previous generation:
- configurable counter width;
- synchronous reset with a clear sweep;
- read-modify-write forwarding for back-to-back hits on the same node;
- merging of simultaneous increment and decrement;
- underflow and overflow reporting.

---
 rtl/degree_table.sv | 192 +++++++++++++++++++
 tb/tb_degree_table.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/degree_table.sv
// degree_table: per-node in-degree counter table.
// Edges stream in as increments; the scheduler issues decrements and gets back
// each post-decrement degree with zero/underflow flags. Two RMW lanes share a
// dual-port synchronous-read RAM: lane 0 carries increments, lane 1 carries
// decrements (or a merged inc+dec on the same node). A reset starts a clear
// sweep over every address before the table accepts work.
// Build option: define DEGREE_TABLE_SATURATE_EN to make increments saturate at
// all-ones instead of wrapping to 0 (err_overflow is raised in both builds).
module degree_table #(
  parameter int MAX_NODES  = 1024,
  parameter int NODE_WIDTH = $clog2(MAX_NODES),
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  ready,
  input  logic                  inc_valid,
  input  logic [NODE_WIDTH-1:0] inc_node,
  input  logic                  dec_valid,
  input  logic [NODE_WIDTH-1:0] dec_node,
  output logic                  res_valid,
  output logic [NODE_WIDTH-1:0] res_node,
  output logic [CNT_WIDTH-1:0]  res_degree,
  output logic                  res_zero,
  output logic                  res_underflow,
  output logic                  err_underflow,
  output logic                  err_overflow
);
  localparam int DEPTH = 2**NODE_WIDTH;
  localparam int LANES = 2;

  typedef enum logic {CLEAR, RUN} state_t;
  typedef enum logic [1:0] {OP_INC, OP_DEC, OP_MRG} op_t;

  typedef struct packed {
    logic                  vld;
    op_t                   op;
    logic [NODE_WIDTH-1:0] node;
  } req_t;

  state_t                             state_q, state_d;
  logic [NODE_WIDTH-1:0]              clr_addr;
  logic [CNT_WIDTH-1:0]               mem [DEPTH];

  req_t [LANES-1:0]                   s0_req, s1_req;
  logic [LANES-1:0]                   fwd_hit, s1_fwd_hit, s1_ovf;
  logic [LANES-1:0][CNT_WIDTH-1:0]    fwd_val, s1_fwd_val, rd_data, s1_old, s1_new;
  logic                               same_node, dec_uf;

  logic                               s2_vld, s2_uf;
  logic [NODE_WIDTH-1:0]              s2_node;
  logic [CNT_WIDTH-1:0]               s2_deg;

  assign ready = (state_q == RUN);

  // State register: reset always restarts the clear sweep.
  always_ff @(posedge clk) begin
    if (reset) state_q <= CLEAR;
    else       state_q <= state_d;
  end

  // Next state: leave CLEAR once the last address has been written.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (clr_addr == '1) state_d = RUN;
      default: state_d = state_q;
    endcase
  end

  // Sweep address counter, one entry per cycle while clearing.
  always_ff @(posedge clk) begin
    if (reset)                 clr_addr <= '0;
    else if (state_q == CLEAR) clr_addr <= clr_addr + 1'b1;
  end

  // S0: build lane requests and detect hits against the values being
  // computed in S1 (those land in the RAM on this same edge, too late for
  // the read). S2 values are already in the RAM by now.
  assign same_node = (inc_node == dec_node);

  always_comb begin
    s0_req[0].vld  = ready & inc_valid & ~(dec_valid & same_node);
    s0_req[0].op   = OP_INC;
    s0_req[0].node = inc_node;
    s0_req[1].vld  = ready & dec_valid;
    s0_req[1].op   = (inc_valid & same_node) ? OP_MRG : OP_DEC;
    s0_req[1].node = dec_node;
    for (int l = 0; l < LANES; l++) begin
      fwd_hit[l] = 1'b0;
      fwd_val[l] = s1_new[1];
      for (int k = 0; k < LANES; k++) begin
        if (s1_req[k].vld && (s1_req[k].node == s0_req[l].node)) begin
          fwd_hit[l] = 1'b1;
          fwd_val[l] = s1_new[k];
        end
      end
    end
  end

  // RAM: synchronous read for both lanes; write port is the clear sweep or
  // the S1 write-back of each active lane (lanes never share a node).
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) rd_data[l] <= mem[s0_req[l].node];
    if (!reset) begin
      if (state_q == CLEAR) mem[clr_addr] <= '0;
      else begin
        for (int l = 0; l < LANES; l++)
          if (s1_req[l].vld) mem[s1_req[l].node] <= s1_new[l];
      end
    end
  end

  // S0 -> S1 pipeline register; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_req     <= '0;
      s1_fwd_hit <= '0;
      s1_fwd_val <= '0;
    end else begin
      s1_req     <= s0_req;
      s1_fwd_hit <= fwd_hit;
      s1_fwd_val <= fwd_val;
    end
  end

  // S1: pick forwarded or RAM data and apply the lane's delta.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      s1_old[l] = s1_fwd_hit[l] ? s1_fwd_val[l] : rd_data[l];
      s1_new[l] = s1_old[l];
      s1_ovf[l] = 1'b0;
      case (s1_req[l].op)
        OP_INC: begin
          s1_ovf[l] = s1_req[l].vld & (&s1_old[l]);
`ifdef DEGREE_TABLE_SATURATE_EN
          if (!(&s1_old[l])) s1_new[l] = s1_old[l] + 1'b1;
`else
          s1_new[l] = s1_old[l] + 1'b1;
`endif
        end
        OP_DEC:  if (s1_old[l] != '0) s1_new[l] = s1_old[l] - 1'b1;
        default: s1_new[l] = s1_old[l];
      endcase
    end
  end

  // A merged op acts as increment-then-decrement, so only a plain decrement
  // can underflow.
  assign dec_uf = (s1_req[1].op == OP_DEC) && (s1_old[1] == '0);

  // S2 register for the decrement lane plus the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_vld       <= 1'b0;
      s2_node      <= '0;
      s2_deg       <= '0;
      s2_uf        <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      s2_vld       <= s1_req[1].vld;
      err_overflow <= err_overflow | (|s1_ovf);
      if (s1_req[1].vld) begin
        s2_node <= s1_req[1].node;
        s2_deg  <= s1_new[1];
        s2_uf   <= dec_uf;
      end
    end
  end

  // Result registers: one-cycle pulse per accepted decrement.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid     <= 1'b0;
      res_node      <= '0;
      res_degree    <= '0;
      res_zero      <= 1'b0;
      res_underflow <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      res_valid     <= s2_vld;
      err_underflow <= err_underflow | (s2_vld & s2_uf);
      if (s2_vld) begin
        res_node      <= s2_node;
        res_degree    <= s2_deg;
        res_zero      <= (s2_deg == '0) & ~s2_uf;
        res_underflow <= s2_uf;
      end
    end
  end

endmodule

// File: tb/tb_degree_table.sv
// Bench for degree_table: a 16-entry, 8-bit table checked through a result
// scoreboard fed by a sequential reference model, plus a 2-bit-counter
// instance for the overflow case.
module tb_degree_table;
  localparam int NW = 4;

  typedef struct {
    logic [NW-1:0] node;
    logic [7:0]    deg;
    logic          zero;
    logic          uf;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          inc_valid = 1'b0, dec_valid = 1'b0;
  logic [NW-1:0] inc_node = '0, dec_node = '0;
  logic          ready, res_valid, res_zero, res_underflow, err_underflow, err_overflow;
  logic [NW-1:0] res_node;
  logic [7:0]    res_degree;

  logic          i2_valid = 1'b0, d2_valid = 1'b0;
  logic [NW-1:0] i2_node = '0, d2_node = '0;
  logic          ready2, res2_valid, res2_zero, res2_underflow, err2_underflow, err2_overflow;
  logic [NW-1:0] res2_node;
  logic [1:0]    res2_degree;

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  logic [7:0] model [16];
  exp_t       sb [$];

  degree_table #(.MAX_NODES(16), .NODE_WIDTH(NW), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .ready(ready),
    .inc_valid(inc_valid), .inc_node(inc_node),
    .dec_valid(dec_valid), .dec_node(dec_node),
    .res_valid(res_valid), .res_node(res_node), .res_degree(res_degree),
    .res_zero(res_zero), .res_underflow(res_underflow),
    .err_underflow(err_underflow), .err_overflow(err_overflow)
  );

  degree_table #(.MAX_NODES(16), .NODE_WIDTH(NW), .CNT_WIDTH(2)) dut_w2 (
    .clk(clk), .reset(reset), .ready(ready2),
    .inc_valid(i2_valid), .inc_node(i2_node),
    .dec_valid(d2_valid), .dec_node(d2_node),
    .res_valid(res2_valid), .res_node(res2_node), .res_degree(res2_degree),
    .res_zero(res2_zero), .res_underflow(res2_underflow),
    .err_underflow(err2_underflow), .err_overflow(err2_overflow)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Drive one cycle of stimulus; if the table is ready, advance the model and
  // queue the expected result of any decrement.
  task automatic drive(input logic iv, input logic [NW-1:0] inn,
                       input logic dv, input logic [NW-1:0] dn);
    exp_t e;
    inc_valid = iv; inc_node = inn; dec_valid = dv; dec_node = dn;
    if (ready) begin
      e.deg = '0; e.uf = 1'b0;
      if (iv && dv && inn == dn) begin
        e.deg = model[dn];
      end else begin
        if (iv) model[inn] = model[inn] + 8'd1;
        if (dv) begin
          if (model[dn] == 8'd0) e.uf = 1'b1;
          else begin
            model[dn] = model[dn] - 8'd1;
            e.deg = model[dn];
          end
        end
      end
      if (dv) begin
        e.node = dn;
        e.zero = (e.deg == 8'd0) && !e.uf;
        e.cyc  = cyc + 3;
        sb.push_back(e);
      end
    end
    @(posedge clk); #1;
    inc_valid = 1'b0; dec_valid = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mon();
    exp_t e;
    forever begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_result: node=%0d degree=%0d underflow=%0b cycle=%0d",
                   res_node, res_degree, res_underflow, cyc);
        end else begin
          e = sb.pop_front();
          if (res_node !== e.node || res_degree !== e.deg || res_zero !== e.zero ||
              res_underflow !== e.uf || cyc != e.cyc) begin
            miscompares++;
            $display("FAIL result: got node=%0d deg=%0d zero=%0b uf=%0b cyc=%0d, want node=%0d deg=%0d zero=%0b uf=%0b cyc=%0d",
                     res_node, res_degree, res_zero, res_underflow, cyc,
                     e.node, e.deg, e.zero, e.uf, e.cyc);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    int lows;
    reset = 1'b1;
    settle(2);
    reset = 1'b0;
    settle(5);
    reset = 1'b1;           // mid-sweep: must restart from address 0
    settle(1);
    reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready === 1'b1) break;
      lows++;
      vectors++;
      if ({res_valid, res_zero, res_underflow, err_underflow, err_overflow} !== 5'b0 ||
          res_node !== '0 || res_degree !== '0) begin
        miscompares++;
        $display("FAIL sweep_outputs: valid=%0b node=%0d deg=%0d zero=%0b uf=%0b eu=%0b eo=%0b, want all 0",
                 res_valid, res_node, res_degree, res_zero, res_underflow, err_underflow, err_overflow);
      end
    end
    vectors++;
    if (lows != 16) begin
      miscompares++;
      $display("FAIL sweep_length: ready low for %0d cycles, want 16", lows);
    end
    vectors++;
    if (ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_high: ready=%0b, want 1", ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) drive(1'b1, 4'd5, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) drive(1'b0, 4'd0, 1'b1, 4'd5);
    settle(4);
  endtask

  task automatic test_merge();
    vectors++;
    if (err_underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL err_underflow_clean: got %0b, want 0", err_underflow);
    end
    drive(1'b1, 4'd3, 1'b1, 4'd3);
    drive(1'b0, 4'd0, 1'b1, 4'd3);
    settle(4);
    vectors++;
    if (err_underflow !== 1'b1) begin
      miscompares++;
      $display("FAIL err_underflow_sticky: got %0b, want 1", err_underflow);
    end
  endtask

  task automatic test_dual_lane();
    for (int i = 0; i < 4; i++) drive(1'b1, 4'd2, 1'b0, 4'd0);
    settle(2);
    drive(1'b1, 4'd1, 1'b1, 4'd2);
    settle(3);
    drive(1'b0, 4'd0, 1'b1, 4'd1);
    settle(4);
  endtask

  task automatic test_overflow();
    int lat;
    logic [1:0] exp_deg;
    logic exp_uf;
`ifdef DEGREE_TABLE_SATURATE_EN
    exp_deg = 2'd2; exp_uf = 1'b0;
`else
    exp_deg = 2'd0; exp_uf = 1'b1;
`endif
    vectors++;
    if (ready2 !== 1'b1) begin
      miscompares++;
      $display("FAIL w2_ready: got %0b, want 1", ready2);
    end
    i2_valid = 1'b1; i2_node = 4'd7;
    settle(3);
    i2_valid = 1'b0;
    settle(3);
    vectors++;
    if (err2_overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL w2_no_overflow_at_3: got %0b, want 0", err2_overflow);
    end
    i2_valid = 1'b1;
    settle(1);
    i2_valid = 1'b0; d2_valid = 1'b1; d2_node = 4'd7;
    settle(1);
    d2_valid = 1'b0;
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res2_valid === 1'b1) begin lat = i; break; end
    end
    vectors++;
    if (lat != 2) begin
      miscompares++;
      $display("FAIL w2_latency: result after %0d negedges, want 2", lat);
    end
    vectors++;
    if (res2_node !== 4'd7 || res2_degree !== exp_deg || res2_underflow !== exp_uf || res2_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL w2_result: got node=%0d deg=%0d uf=%0b zero=%0b, want node=7 deg=%0d uf=%0b zero=0",
               res2_node, res2_degree, res2_underflow, res2_zero, exp_deg, exp_uf);
    end
    settle(1);
    vectors++;
    if (err2_overflow !== 1'b1 || err2_underflow !== exp_uf) begin
      miscompares++;
      $display("FAIL w2_sticky: got eo=%0b eu=%0b, want eo=1 eu=%0b", err2_overflow, err2_underflow, exp_uf);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++)
      drive(1'($urandom_range(0, 1)), NW'($urandom_range(8, 11)),
            1'($urandom_range(0, 1)), NW'($urandom_range(8, 11)));
    settle(4);
    vectors++;
    if (err_overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL random_overflow: got %0b, want 0", err_overflow);
    end
  endtask

  task automatic test_reset_midflight();
    drive(1'b1, 4'd6, 1'b0, 4'd0);
    settle(2);
    dec_valid = 1'b1; dec_node = 4'd6;   // accepted, result must never appear
    @(posedge clk); #1;
    dec_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({ready, res_valid, res_zero, res_underflow, err_underflow, err_overflow} !== 6'b0 ||
        res_node !== '0 || res_degree !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: ready=%0b valid=%0b node=%0d deg=%0d zero=%0b uf=%0b eu=%0b eo=%0b, want all 0",
               ready, res_valid, res_node, res_degree, res_zero, res_underflow, err_underflow, err_overflow);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ready === 1'b1) break;
    end
    vectors++;
    if (ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_reset: got %0b, want 1", ready);
    end
    foreach (model[i]) model[i] = 8'd0;
    drive(1'b0, 4'd0, 1'b1, 4'd6);
    drive(1'b0, 4'd0, 1'b1, 4'd2);
    settle(4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (model[i]) model[i] = 8'd0;
    fork
      mon();
    join_none
    test_reset();
    test_back_to_back();
    test_merge();
    test_dual_lane();
    test_overflow();
    test_random();
    test_reset_midflight();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL pending_results: %0d expected results never seen, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
